// File: rtl/dbus_interconnect_pkg.sv
// dbus_interconnect_pkg: shared types, widths and byte-enable legality helper for the data bus.
package dbus_interconnect_pkg;
  localparam int DBUS_DATA_W = 32;
  localparam int DBUS_BE_W = 4;
  typedef logic [DBUS_DATA_W-1:0] word_t;
  typedef logic [31:0] address_t;
  typedef enum logic [1:0] {DBUS_IDLE, DBUS_ACCESS, DBUS_RESP} dbus_state_e;
  function automatic logic be_legal(input logic [DBUS_BE_W-1:0] be);
    return be inside {4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111};
  endfunction
endpackage

// File: rtl/dbus_decoder.sv
// dbus_decoder: combinational region decode of a data-bus address.
// Alignment checking only exists when DBUS_ALIGN_CHECK_EN is defined.
module dbus_decoder
  import dbus_interconnect_pkg::*;
#(
  parameter int N_TGT = 4,
  parameter int ADDR_W = 12,
  parameter int SEL_W = 2
) (
  input  address_t             req_addr,
`ifdef DBUS_ALIGN_CHECK_EN
  input  logic [DBUS_BE_W-1:0] req_be,
`endif
  output logic [SEL_W-1:0]     idx,
  output logic [ADDR_W-1:0]    ofs,
  output logic                 unmapped,
  output logic                 misaligned
);
  assign idx = req_addr[ADDR_W +: SEL_W];
  assign ofs = req_addr[ADDR_W-1:0] & ~ADDR_W'(3);
  assign unmapped = (32'(idx) >= N_TGT) || ((req_addr >> (ADDR_W + SEL_W)) != '0);
`ifdef DBUS_ALIGN_CHECK_EN
  assign misaligned = (req_addr[1:0] != 2'b00) || !be_legal(req_be);
`else
  assign misaligned = 1'b0;
`endif
endmodule

// File: rtl/dbus_interconnect.sv
// dbus_interconnect: core load/store port to N_TGT memory-mapped targets, one registered response per request.
// Define DBUS_ALIGN_CHECK_EN to fault misaligned addresses and illegal byte-enable patterns.
module dbus_interconnect
  import dbus_interconnect_pkg::*;
#(
  parameter int N_TGT = 4,
  parameter int ADDR_W = 12,
  parameter int TIMEOUT = 15
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_write,
  input  address_t               req_addr,
  input  word_t                  req_wdata,
  input  logic [DBUS_BE_W-1:0]   req_be,
  output logic                   rsp_valid,
  output word_t                  rsp_rdata,
  output logic                   rsp_err,
  output logic [N_TGT-1:0]       tgt_sel,
  output logic                   tgt_write,
  output logic [ADDR_W-1:0]      tgt_addr,
  output word_t                  tgt_wdata,
  output logic [DBUS_BE_W-1:0]   tgt_be,
  input  logic [N_TGT-1:0]       tgt_ack,
  input  logic [N_TGT*32-1:0]    tgt_rdata
);
  localparam int SEL_W = N_TGT > 1 ? $clog2(N_TGT) : 1;
  dbus_state_e state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [SEL_W-1:0] idx, idx_q, idx_d;
  logic [ADDR_W-1:0] ofs, addr_q, addr_d;
  logic [DBUS_BE_W-1:0] be_q, be_d;
  logic write_q, write_d, err_q, err_d, unmapped, misaligned;
  word_t wdata_q, wdata_d, rdata_q, rdata_d;
  dbus_decoder #(.N_TGT(N_TGT), .ADDR_W(ADDR_W), .SEL_W(SEL_W)) u_dec (
    .req_addr(req_addr),
`ifdef DBUS_ALIGN_CHECK_EN
    .req_be(req_be),
`endif
    .idx(idx),
    .ofs(ofs),
    .unmapped(unmapped),
    .misaligned(misaligned)
  );
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    idx_d = idx_q;
    write_d = write_q;
    addr_d = addr_q;
    wdata_d = wdata_q;
    be_d = be_q;
    rdata_d = rdata_q;
    err_d = err_q;
    case (state_q)
      DBUS_IDLE: if (req_valid) begin
        idx_d = idx;
        write_d = req_write;
        addr_d = ofs;
        wdata_d = req_wdata;
        be_d = req_be;
        cnt_d = '0;
        rdata_d = '0;
        err_d = unmapped || misaligned;
        state_d = err_d ? DBUS_RESP : DBUS_ACCESS;
      end
      // Ack is tested before the timeout so a same-cycle ack still completes cleanly.
      DBUS_ACCESS: if (tgt_ack[idx_q]) begin
        state_d = DBUS_RESP;
        err_d = 1'b0;
        rdata_d = write_q ? '0 : tgt_rdata[32*idx_q +: 32];
      end else if (cnt_q == 8'(TIMEOUT - 1)) begin
        state_d = DBUS_RESP;
        err_d = 1'b1;
        rdata_d = '0;
      end else cnt_d = cnt_q + 8'd1;
      default: state_d = DBUS_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state_q <= DBUS_IDLE;
      cnt_q <= '0;
      idx_q <= '0;
      write_q <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
      be_q <= '0;
      rdata_q <= '0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      write_q <= write_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      be_q <= be_d;
      rdata_q <= rdata_d;
      err_q <= err_d;
    end
  assign req_ready = state_q == DBUS_IDLE;
  assign rsp_valid = state_q == DBUS_RESP;
  assign rsp_rdata = rsp_valid ? rdata_q : '0;
  assign rsp_err = rsp_valid && err_q;
  assign tgt_sel = state_q == DBUS_ACCESS ? N_TGT'(1) << idx_q : '0;
  assign tgt_write = write_q;
  assign tgt_addr = addr_q;
  assign tgt_wdata = wdata_q;
  assign tgt_be = be_q;
endmodule

// File: tb/tb_dbus_interconnect.sv
// tb_dbus_interconnect: scoreboard bench for dbus_interconnect with three targets (idx 3 unmapped).
module tb_dbus_interconnect;
  localparam int N = 3;
  localparam int AW = 12;
  localparam int TO = 15;
  typedef struct {logic [31:0] rd; logic err;} exp_t;
  logic clk = 1'b0, reset_n = 1'b0;
  logic req_valid = 1'b0, req_write = 1'b0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic [3:0] req_be = '0;
  logic req_ready, rsp_valid, rsp_err, tgt_write;
  logic [31:0] rsp_rdata, tgt_wdata;
  logic [N-1:0] tgt_sel;
  logic [N-1:0] tgt_ack = '0;
  logic [AW-1:0] tgt_addr;
  logic [3:0] tgt_be;
  logic [N*32-1:0] tgt_rdata = '0;
  int n_vec = 0, n_bad = 0;
  exp_t sb[$];
  dbus_interconnect #(.N_TGT(N), .ADDR_W(AW), .TIMEOUT(TO)) dut (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .tgt_sel(tgt_sel),
    .tgt_write(tgt_write), .tgt_addr(tgt_addr), .tgt_wdata(tgt_wdata), .tgt_be(tgt_be),
    .tgt_ack(tgt_ack), .tgt_rdata(tgt_rdata)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  always @(negedge clk) begin
    exp_t e;
    if (reset_n && rsp_valid) begin
      if (sb.size() == 0) chk("rsp_unexpected", 32'd1, 32'd0);
      else begin
        e = sb.pop_front();
        chk("rsp_rdata", rsp_rdata, e.rd);
        chk("rsp_err", {31'b0, rsp_err}, {31'b0, e.err});
      end
    end
  end
  // tgt < 0: unmapped/faulted, no target access; waits < 0: target never acks.
  task automatic run(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                     input logic [3:0] be, input int tgt, input int waits,
                     input logic [31:0] rd, input bit noise);
    logic exp_err;
    int sel_n, exp_n;
    exp_err = tgt < 0 || waits < 0 || waits >= TO;
    exp_n = tgt < 0 ? 0 : (waits < 0 || waits >= TO) ? TO : waits + 1;
    @(negedge clk);
    chk("req_ready", {31'b0, req_ready}, 32'd1);
    req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wd; req_be = be;
    sb.push_back('{rd: (exp_err || wr) ? 32'd0 : rd, err: exp_err});
    tgt_rdata = {N{32'h5A5A_1234}};
    if (tgt >= 0) tgt_rdata[32*tgt +: 32] = rd;
    @(negedge clk);
    req_valid = 1'b0;
    req_addr = 32'h0000_0000;
    sel_n = 0;
    if (tgt >= 0) begin
      chk("tgt_addr", {20'b0, tgt_addr}, {20'b0, addr[11:2], 2'b00});
      chk("tgt_wdata", tgt_wdata, wd);
      chk("tgt_be", {28'b0, tgt_be}, {28'b0, be});
      for (int c = 0; c < 40; c++) begin
        if (tgt_sel == '0) break;
        chk("tgt_sel", {29'b0, tgt_sel}, 32'd1 << tgt);
        chk("tgt_write", {31'b0, tgt_write}, {31'b0, wr});
        sel_n++;
        tgt_ack = (c == waits ? N'(1 << tgt) : N'(0)) | (noise ? ~N'(1 << tgt) : N'(0));
        @(negedge clk);
      end
      tgt_ack = '0;
    end
    chk("sel_cycles", sel_n, exp_n);
    chk("tgt_sel_off", {29'b0, tgt_sel}, 32'd0);
    chk("rsp_valid", {31'b0, rsp_valid}, 32'd1);
    @(negedge clk);
    chk("rsp_pulse", {31'b0, rsp_valid}, 32'd0);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end
  initial begin
    logic [31:0] a, d;
    int t, w;
    #2;
    chk("rst_ready", {31'b0, req_ready}, 32'd1);
    chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    chk("rst_rsp_err", {31'b0, rsp_err}, 32'd0);
    chk("rst_tgt_sel", {29'b0, tgt_sel}, 32'd0);
    chk("rst_tgt_regs", {tgt_wdata[31:17] | {3'b0, tgt_addr}, tgt_be, tgt_write, tgt_wdata[16:5]}, 32'd0);
    chk("rst_tgt_wdata", tgt_wdata, 32'd0);
    @(negedge clk);
    @(negedge clk) reset_n = 1'b1;
    run(1'b0, 32'h0000_1008, 32'h0, 4'hF, 1, 0, 32'hCAFE_BABE, 1'b0);
    run(1'b1, 32'h0000_0004, 32'h1234_5678, 4'hF, 0, 3, 32'hFFFF_FFFF, 1'b0);
    run(1'b0, 32'h0000_3000, 32'h0, 4'hF, -1, 0, 32'h0, 1'b0);
    run(1'b0, 32'h0001_0000, 32'h0, 4'hF, -1, 0, 32'h0, 1'b0);
    run(1'b0, 32'h0000_2010, 32'h0, 4'hF, 2, -1, 32'h1111_2222, 1'b1);
    run(1'b0, 32'h0000_2010, 32'h0, 4'hF, 2, 14, 32'h3333_4444, 1'b1);
    run(1'b0, 32'h0000_1ffc, 32'h0, 4'hF, 1, 2, 32'h7777_8888, 1'b1);
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h0000_0040; req_wdata = 32'hA5A5_A5A5; req_be = 4'hF;
    @(negedge clk) req_valid = 1'b0;
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_tgt_sel", {29'b0, tgt_sel}, 32'd0);
    chk("arst_ready", {31'b0, req_ready}, 32'd1);
    chk("arst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("arst_tgt_wdata", tgt_wdata, 32'd0);
    chk("arst_tgt_addr", {20'b0, tgt_addr}, 32'd0);
    chk("arst_tgt_write", {31'b0, tgt_write}, 32'd0);
    @(negedge clk) reset_n = 1'b1;
    run(1'b0, 32'h0000_0040, 32'h0, 4'hF, 0, 1, 32'h0BAD_F00D, 1'b0);
`ifdef DBUS_ALIGN_CHECK_EN
    run(1'b0, 32'h0000_0002, 32'h0, 4'hF, -1, 0, 32'h0, 1'b0);
    run(1'b0, 32'h0000_0000, 32'h0, 4'b0110, -1, 0, 32'h0, 1'b0);
`else
    run(1'b0, 32'h0000_0002, 32'h0, 4'hF, 0, 0, 32'h2468_ACE0, 1'b0);
    run(1'b0, 32'h0000_0000, 32'h0, 4'b0110, 0, 1, 32'h1357_9BDF, 1'b0);
`endif
    for (int i = 0; i < 6; i++) begin
      t = $urandom_range(0, N - 1);
      w = $urandom_range(0, 5);
      d = $urandom;
      a = {18'b0, 2'(t), 12'($urandom_range(0, 1023) * 4)};
      run(1'($urandom_range(0, 1)), a, $urandom, 4'hF, t, w, d, 1'($urandom_range(0, 1)));
    end
    repeat (3) @(negedge clk);
    chk("sb_empty", sb.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
